// File: rtl/mem_wb_if.sv
// mem_wb_if: MEM->WB slot bus; master drives the MEM-side fields, slave presents the WB-side fields
interface mem_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              mem_valid_i;
  logic [DATA_W-1:0] mem_pc_i;
  logic [DATA_W-1:0] mem_write_data_i;
  logic [ADDR_W-1:0] mem_write_addr_i;
  logic              mem_write_en_i;
  logic [DATA_W-1:0] mem_hi_i;
  logic [DATA_W-1:0] mem_lo_i;
  logic              mem_whilo_i;
  logic              wb_valid_o;
  logic [DATA_W-1:0] wb_pc_o;
  logic [DATA_W-1:0] wb_write_data_o;
  logic [ADDR_W-1:0] wb_write_addr_o;
  logic              wb_write_en_o;
  logic [DATA_W-1:0] wb_hi_o;
  logic [DATA_W-1:0] wb_lo_o;
  logic              wb_whilo_o;
  modport master (
    output mem_valid_i, mem_pc_i, mem_write_data_i, mem_write_addr_i, mem_write_en_i,
           mem_hi_i, mem_lo_i, mem_whilo_i,
    input  wb_valid_o, wb_pc_o, wb_write_data_o, wb_write_addr_o, wb_write_en_o,
           wb_hi_o, wb_lo_o, wb_whilo_o
  );
  modport slave (
    input  mem_valid_i, mem_pc_i, mem_write_data_i, mem_write_addr_i, mem_write_en_i,
           mem_hi_i, mem_lo_i, mem_whilo_i,
    output wb_valid_o, wb_pc_o, wb_write_data_o, wb_write_addr_o, wb_write_en_o,
           wb_hi_o, wb_lo_o, wb_whilo_o
  );
endinterface

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register (clk, async rst, stall/flush in; bus slot MEM->WB; debug_wb_* trace and retire_count out)
module mem_wb_reg #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int STALL_W   = 6,
  parameter int STALL_MEM = 4,
  parameter int STALL_WB  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  mem_wb_if.slave            bus,
  output logic [DATA_W-1:0]  debug_wb_pc,
  output logic [3:0]         debug_wb_rf_wen,
  output logic [ADDR_W-1:0]  debug_wb_rf_wnum,
  output logic [DATA_W-1:0]  debug_wb_rf_wdata,
  output logic [31:0]        retire_count
);
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              en;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              whilo;
  } slot_t;
  slot_t       slot_in, slot_d, slot_q;
  logic [31:0] retire_d, retire_q;
  logic        bubble, hold, load;
  always_comb begin
    bubble  = flush | (stall[STALL_MEM] & ~stall[STALL_WB]);
    hold    = ~flush & stall[STALL_MEM] & stall[STALL_WB];
    load    = ~bubble & ~hold;
    // r0 is hard-wired zero, so writes to it are dropped here rather than in the regfile
    slot_in = '{valid: bus.mem_valid_i,
                pc:    bus.mem_pc_i,
                data:  bus.mem_write_data_i,
                addr:  bus.mem_write_addr_i,
                en:    bus.mem_write_en_i & bus.mem_valid_i & (bus.mem_write_addr_i != '0),
                hi:    bus.mem_hi_i,
                lo:    bus.mem_lo_i,
                whilo: bus.mem_whilo_i & bus.mem_valid_i};
    slot_d   = bubble ? '0 : hold ? slot_q : slot_in;
    retire_d = retire_q + {31'b0, load & bus.mem_valid_i};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q   <= '0;
      retire_q <= '0;
    end else begin
      slot_q   <= slot_d;
      retire_q <= retire_d;
    end
  end
  assign bus.wb_valid_o      = slot_q.valid;
  assign bus.wb_pc_o         = slot_q.pc;
  assign bus.wb_write_data_o = slot_q.data;
  assign bus.wb_write_addr_o = slot_q.addr;
  assign bus.wb_write_en_o   = slot_q.en;
  assign bus.wb_hi_o         = slot_q.hi;
  assign bus.wb_lo_o         = slot_q.lo;
  assign bus.wb_whilo_o      = slot_q.whilo;
  assign debug_wb_pc         = slot_q.pc;
  assign debug_wb_rf_wen     = {4{slot_q.en}};
  assign debug_wb_rf_wnum    = slot_q.addr;
  assign debug_wb_rf_wdata   = slot_q.data;
  assign retire_count        = retire_q;
endmodule

// File: tb/tb_mem_wb_reg.sv
// tb_mem_wb_reg: scoreboard bench for mem_wb_reg with directed cases and random stall/flush/data traffic
module tb_mem_wb_reg;
  logic        clk = 0;
  logic        rst = 1;
  logic [5:0]  stall = '0;
  logic        flush = 0;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata, retire_count;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  int          checks = 0;
  int          failures = 0;
  mem_wb_if bus ();
  mem_wb_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .retire_count(retire_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        valid;
    logic [31:0] pc, data, hi, lo, cnt;
    logic [4:0]  addr;
    logic        en, whilo;
  } exp_t;
  exp_t m = '{default: '0};
  exp_t sb[$];
  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h @%0t", n, act, req, $time);
    end
  endtask
  task automatic chk_all(exp_t e);
    chk("wb_valid", 32'(bus.wb_valid_o), 32'(e.valid));
    chk("wb_pc", bus.wb_pc_o, e.pc);
    chk("wb_data", bus.wb_write_data_o, e.data);
    chk("wb_addr", 32'(bus.wb_write_addr_o), 32'(e.addr));
    chk("wb_en", 32'(bus.wb_write_en_o), 32'(e.en));
    chk("wb_hi", bus.wb_hi_o, e.hi);
    chk("wb_lo", bus.wb_lo_o, e.lo);
    chk("wb_whilo", 32'(bus.wb_whilo_o), 32'(e.whilo));
    chk("dbg_pc", debug_wb_pc, e.pc);
    chk("dbg_wen", 32'(debug_wb_rf_wen), e.en ? 32'hF : 32'h0);
    chk("dbg_wnum", 32'(debug_wb_rf_wnum), 32'(e.addr));
    chk("dbg_wdata", debug_wb_rf_wdata, e.data);
    chk("retire_count", retire_count, e.cnt);
  endtask
  always begin
    @(posedge clk);
    #1;
    if (sb.size() != 0) chk_all(sb.pop_front());
  end
  // Drives one MEM slot at a negedge, advances the reference model, queues its expectation
  task automatic step(logic v, logic [31:0] pc, logic [31:0] d, logic [4:0] a, logic en,
                      logic [31:0] hi, logic [31:0] lo, logic wh, logic [5:0] st, logic fl);
    bus.mem_valid_i = v;  bus.mem_pc_i = pc;  bus.mem_write_data_i = d;
    bus.mem_write_addr_i = a;  bus.mem_write_en_i = en;
    bus.mem_hi_i = hi;  bus.mem_lo_i = lo;  bus.mem_whilo_i = wh;
    stall = st;  flush = fl;
    if (fl || (st[4] && !st[5])) begin
      m = '{valid: 0, pc: 0, data: 0, hi: 0, lo: 0, cnt: m.cnt, addr: 0, en: 0, whilo: 0};
    end else if (!(st[4] && st[5])) begin
      m = '{valid: v, pc: pc, data: d, hi: hi, lo: lo, cnt: m.cnt + (v ? 1 : 0),
            addr: a, en: en && v && a != 0, whilo: wh && v};
    end
    sb.push_back(m);
    @(negedge clk);
  endtask
  initial begin
    bus.mem_valid_i = 0;  bus.mem_pc_i = 0;  bus.mem_write_data_i = 0;
    bus.mem_write_addr_i = 0;  bus.mem_write_en_i = 0;
    bus.mem_hi_i = 0;  bus.mem_lo_i = 0;  bus.mem_whilo_i = 0;
    #3 chk_all(m);
    @(negedge clk);
    rst = 0;
    step(1, 32'hBFC0_0010, 32'h1234_5678, 8, 1, 32'h1, 32'h2, 1, 6'b0, 0);
    step(1, 32'hBFC0_0014, 32'hDEAD_BEEF, 0, 1, 32'h3, 32'h4, 0, 6'b0, 0);
    step(1, 32'hBFC0_0018, 32'hCAFE_F00D, 9, 1, 32'h5, 32'h6, 1, 6'b0, 0);
    for (int i = 0; i < 3; i++)
      step(1, 32'h0000_1000 + i, 32'h5555_0000 + i, 5'(i + 3), 1, 32'h7, 32'h8, 1, 6'b111111, 0);
    step(1, 32'hBFC0_001C, 32'hAAAA_AAAA, 10, 1, 32'h9, 32'hA, 1, 6'b011111, 0);
    step(1, 32'hBFC0_0020, 32'h1111_2222, 11, 1, 32'hB, 32'hC, 1, 6'b0, 0);
    step(1, 32'hBFC0_0024, 32'h3333_4444, 12, 1, 32'hD, 32'hE, 1, 6'b111111, 1);
    step(0, 32'hBFC0_0028, 32'h5555_6666, 13, 1, 32'hF, 32'h10, 1, 6'b0, 0);
    step(1, 32'hBFC0_002C, 32'h7777_8888, 14, 1, 32'h11, 32'h12, 1, 6'b100000, 0);
    for (int i = 0; i < 300; i++) begin
      logic [5:0] st;
      st = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b0;
      step($urandom_range(0, 3) != 0, $urandom, $urandom,
           ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom), 1'($urandom), $urandom, $urandom,
           1'($urandom), st, $urandom_range(0, 7) == 0);
    end
    step(1, 32'hBFC0_0100, 32'h0BAD_CAFE, 17, 1, 32'h21, 32'h22, 1, 6'b0, 0);
    bus.mem_pc_i = 32'hBFC0_0104;
    #2 rst = 1;
    #1 begin
      m = '{default: '0};
      chk_all(m);
    end
    @(negedge clk);
    chk_all(m);
    rst = 0;
    force dut.retire_q = 32'hFFFF_FFFF;
    #1 release dut.retire_q;
    m.cnt = 32'hFFFF_FFFF;
    step(1, 32'hBFC0_0200, 32'h1357_9BDF, 4, 1, 32'h1, 32'h2, 0, 6'b0, 0);
    step(0, 32'hBFC0_0204, 32'h2468_ACE0, 5, 1, 32'h3, 32'h4, 1, 6'b0, 0);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
